rx_bit_timer: RTL and testbench
===============================

RX_BIT_TIMER -- requirements
Module: rx_bit_timer

Interface
REQ-001 The block SHALL use parameter CLKS_PER_BIT, default 8, meaning clocks per USB bit period.
REQ-002 The block SHALL use parameter SAMPLE_POINT, default 4, meaning the phase value at which a bit is sampled (1..CLKS_PER_BIT-1).
REQ-003 The block SHALL use parameter BITS_PER_BYTE, default 8, meaning data bits per received byte.
REQ-004 The block SHALL use parameter MAX_NOEDGE_BITS, default 7, meaning bit periods without a data edge before error.
REQ-005 The block SHALL have port clk, input, 1, meaning system clock, rising edge.
REQ-006 The block SHALL have port n_rst, input, 1, meaning reset, asynchronous, active-low.
REQ-007 The block SHALL have port enable_timer, input, 1, meaning receive-in-progress from the RX controller.
REQ-008 The block SHALL have port d_edge, input, 1, meaning one-cycle pulse on a synchronized D+/D- transition.
REQ-009 The block SHALL have port stuff_bit, input, 1, meaning the current sample is a stuffed bit.
REQ-010 The block SHALL have port shift_enable, output, 1, meaning shift-register sample strobe.
REQ-011 The block SHALL have port byte_received, output, 1, meaning one-cycle pulse after the last bit of a byte.
REQ-012 The block SHALL have port bit_count, output, $clog2(BITS_PER_BYTE)+1, meaning data bits taken in the current byte.
REQ-013 The block SHALL have port bit_error, output, 1, meaning sticky error for too long without an edge.

Function
REQ-014 Phase register: while enable_timer=0 it SHALL load 0; otherwise d_edge=1 SHALL load 1, else it SHALL increment and wrap from CLKS_PER_BIT-1 to 0.
REQ-015 d_edge SHALL be ignored while enable_timer=0.
REQ-016 When d_edge coincides with a phase wrap, the edge SHALL win: phase loads 1 and the no-edge count clears.
REQ-017 shift_enable SHALL be 1 exactly in cycles where enable_timer=1, phase=SAMPLE_POINT and stuff_bit=0; it SHALL have no other path.
REQ-018 A sample with stuff_bit=1 SHALL NOT assert shift_enable and SHALL NOT change bit_count.
REQ-019 bit_count SHALL increment on each shift_enable cycle. At BITS_PER_BYTE-1 it SHALL wrap to 0 and set registered byte_received for exactly the next cycle.
REQ-020 The no-edge counter SHALL clear on d_edge and increment in each enabled cycle with phase=CLKS_PER_BIT-1 and d_edge=0. Reaching MAX_NOEDGE_BITS SHALL set bit_error the following cycle.
REQ-021 bit_error SHALL remain 1 until enable_timer=0, then clear on the next clock.
REQ-022 enable_timer falling mid-byte SHALL clear phase, bit_count and the no-edge counter next clock, with no byte_received.
REQ-023 byte_received already scheduled when enable_timer falls SHALL still be emitted for its one cycle.
REQ-024 All counter arithmetic SHALL be unsigned with widths sized by $clog2 of the parameter ranges, and no counter SHALL exceed its stated maximum.

Reset
REQ-025 Asserting n_rst=0 SHALL asynchronously force phase=0, bit_count=0, no-edge count=0, shift_enable=0, byte_received=0 and bit_error=0.
REQ-026 Reset mid-byte SHALL discard the partial byte, and operation SHALL resume only on the first enabled clock after deassertion.

Structure
REQ-027 The constants USB_CLKS_PER_BIT, USB_SAMPLE_POINT, USB_BITS_PER_BYTE and USB_MAX_NOEDGE_BITS SHALL live in shared package usb_rx_pkg and SHALL serve as parameter defaults.
REQ-028 The block SHALL be flat with no sub-module, keeping edge resync at a single-cycle load; phase, bit and no-edge counters SHALL be local registers.

Verification
REQ-029 enable_timer=1, d_edge at cycle 0, then edges every 8 cycles, stuff_bit=0 -> shift_enable at cycles 4, 12, ..., 60; byte_received at cycle 61; bit_count=0 at cycle 61.
REQ-030 As REQ-029 with stuff_bit=1 during cycle 28 -> no shift_enable at 28; byte_received at cycle 69 instead of 61.
REQ-031 Edge at cycle 0, then no edges -> bit_error rises at cycle 56 and stays 1; enable_timer=0 at cycle 70 -> bit_error=0 at cycle 71.
REQ-032 Edge at cycle 0, second edge at cycle 3 (resync) -> phase=1 at cycle 4 and the next shift_enable at cycle 7, not 4.
REQ-033 n_rst pulsed low at cycle 30 mid-byte -> all outputs 0 immediately, and no byte_received from the partial byte.
REQ-034 enable_timer dropped at cycle 40 with bit_count=4 -> bit_count=0 at cycle 41 and no byte_received.

Source files
------------

// File: rtl/usb_rx_pkg.sv
// Shared USB receive-path constants and small helpers.
// Timer parameters default to these so every RX block agrees on bit timing.
package usb_rx_pkg;

    localparam int USB_CLKS_PER_BIT    = 8;
    localparam int USB_SAMPLE_POINT    = 4;
    localparam int USB_BITS_PER_BYTE   = 8;
    localparam int USB_MAX_NOEDGE_BITS = 7;

    // Width of a counter that must hold values 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/rx_bit_timer.sv
// USB receive bit timer: tracks bit phase, resyncs on data edges,
// strobes bit samples, counts bits per byte and flags edge starvation.
module rx_bit_timer
    import usb_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT    = USB_CLKS_PER_BIT,
    parameter int SAMPLE_POINT    = USB_SAMPLE_POINT,
    parameter int BITS_PER_BYTE   = USB_BITS_PER_BYTE,
    parameter int MAX_NOEDGE_BITS = USB_MAX_NOEDGE_BITS
) (
    input  logic                               clk,
    input  logic                               n_rst,
    input  logic                               enable_timer,
    input  logic                               d_edge,
    input  logic                               stuff_bit,
    output logic                               shift_enable,
    output logic                               byte_received,
    output logic [$clog2(BITS_PER_BYTE):0]     bit_count,
    output logic                               bit_error
);

    localparam int PW = cnt_width(CLKS_PER_BIT - 1);
    localparam int BW = $clog2(BITS_PER_BYTE) + 1;
    localparam int NW = cnt_width(MAX_NOEDGE_BITS);

    localparam logic [PW-1:0] LAST_PHASE = PW'(CLKS_PER_BIT - 1);
    localparam logic [PW-1:0] SAMPLE_PH  = PW'(SAMPLE_POINT);
    localparam logic [BW-1:0] LAST_BIT   = BW'(BITS_PER_BYTE - 1);
    localparam logic [NW-1:0] NOEDGE_MAX = NW'(MAX_NOEDGE_BITS);

    logic [PW-1:0] phase;
    logic [PW-1:0] phase_next;
    logic [BW-1:0] bit_next;
    logic [NW-1:0] noedge;
    logic [NW-1:0] noedge_next;
    logic          byte_next;
    logic          error_next;
    logic          phase_wrap;

    assign phase_wrap   = (phase == LAST_PHASE);
    assign shift_enable = enable_timer && (phase == SAMPLE_PH) && !stuff_bit;

    // An edge always wins over the wrap, so resync is a single-cycle load.
    always_comb begin
        phase_next = '0;
        if (enable_timer) begin
            if (d_edge) begin
                phase_next = PW'(1);
            end else if (!phase_wrap) begin
                phase_next = phase + PW'(1);
            end
        end
    end

    always_comb begin
        bit_next  = '0;
        byte_next = shift_enable && (bit_count == LAST_BIT);
        if (enable_timer) begin
            bit_next = bit_count;
            if (shift_enable) begin
                bit_next = (bit_count == LAST_BIT) ? '0 : bit_count + BW'(1);
            end
        end
    end

    // Starvation counter saturates at its limit; the error flag is sticky.
    always_comb begin
        noedge_next = '0;
        error_next  = 1'b0;
        if (enable_timer) begin
            noedge_next = noedge;
            if (d_edge) begin
                noedge_next = '0;
            end else if (phase_wrap && noedge != NOEDGE_MAX) begin
                noedge_next = noedge + NW'(1);
            end
            error_next = bit_error || (noedge_next == NOEDGE_MAX);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            phase         <= '0;
            bit_count     <= '0;
            noedge        <= '0;
            byte_received <= 1'b0;
            bit_error     <= 1'b0;
        end else begin
            phase         <= phase_next;
            bit_count     <= bit_next;
            noedge        <= noedge_next;
            byte_received <= byte_next;
            bit_error     <= error_next;
        end
    end

endmodule

// File: tb/tb_rx_bit_timer.sv
// Directed bench for rx_bit_timer: cycle-indexed scenarios with
// hand-derived strobe, byte, count and error expectations.
module tb_rx_bit_timer;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       enable_timer;
    logic       d_edge;
    logic       stuff_bit;
    logic       shift_enable;
    logic       byte_received;
    logic [3:0] bit_count;
    logic       bit_error;

    int total = 0;
    int bad   = 0;
    int exp_bc;
    logic es;

    rx_bit_timer dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .enable_timer (enable_timer),
        .d_edge       (d_edge),
        .stuff_bit    (stuff_bit),
        .shift_enable (shift_enable),
        .byte_received(byte_received),
        .bit_count    (bit_count),
        .bit_error    (bit_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int c,
                       input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h",
                   tag, c, obs, exp);
        end
    endtask

    task automatic idle();
        enable_timer = 1'b0;
        d_edge       = 1'b0;
        stuff_bit    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_rst        = 1'b0;
        enable_timer = 1'b0;
        d_edge       = 1'b0;
        stuff_bit    = 1'b0;
        #2;
        chk("rst_shift", 0, 32'(shift_enable), 32'd0);
        chk("rst_br", 0, 32'(byte_received), 32'd0);
        chk("rst_bc", 0, 32'(bit_count), 32'd0);
        chk("rst_err", 0, 32'(bit_error), 32'd0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;

        // Full byte, edges every 8 clocks; enable drops as the byte completes.
        idle();
        exp_bc = 0;
        for (int c = 0; c <= 63; c++) begin
            enable_timer = (c < 61);
            d_edge       = (c % 8 == 0) && (c < 61);
            stuff_bit    = 1'b0;
            @(negedge clk);
            es = (c % 8 == 4) && (c <= 60);
            chk("s1_shift", c, 32'(shift_enable), 32'(es));
            chk("s1_br", c, 32'(byte_received), 32'(c == 61));
            chk("s1_bc", c, 32'(bit_count), 32'(exp_bc));
            chk("s1_err", c, 32'(bit_error), 32'd0);
            if (es) exp_bc = (exp_bc == 7) ? 0 : exp_bc + 1;
            next_cycle();
        end

        // Stuffed bit at cycle 28 delays the byte by one bit period.
        idle();
        exp_bc = 0;
        for (int c = 0; c <= 70; c++) begin
            enable_timer = 1'b1;
            d_edge       = (c % 8 == 0);
            stuff_bit    = (c == 28);
            @(negedge clk);
            es = (c % 8 == 4) && (c != 28);
            chk("s2_shift", c, 32'(shift_enable), 32'(es));
            chk("s2_br", c, 32'(byte_received), 32'(c == 69));
            chk("s2_bc", c, 32'(bit_count), 32'(exp_bc));
            if (es) exp_bc = (exp_bc == 7) ? 0 : exp_bc + 1;
            next_cycle();
        end

        // One edge then silence: error at 56, cleared after enable drops.
        idle();
        for (int c = 0; c <= 72; c++) begin
            enable_timer = (c < 70);
            d_edge       = (c == 0);
            stuff_bit    = 1'b0;
            @(negedge clk);
            chk("s3_err", c, 32'(bit_error), 32'((c >= 56) && (c <= 70)));
            next_cycle();
        end

        // Early second edge resyncs the phase.
        idle();
        for (int c = 0; c <= 12; c++) begin
            enable_timer = 1'b1;
            d_edge       = (c == 0) || (c == 3);
            stuff_bit    = 1'b0;
            @(negedge clk);
            chk("s4_shift", c, 32'(shift_enable), 32'(c == 7));
            if (c == 4) chk("s4_phase", c, 32'(dut.phase), 32'd1);
            next_cycle();
        end

        // Reset pulse at cycle 30 discards the partial byte.
        idle();
        exp_bc = 0;
        for (int c = 0; c <= 70; c++) begin
            enable_timer = 1'b1;
            d_edge       = (c % 8 == 0);
            stuff_bit    = 1'b0;
            n_rst        = (c != 30);
            if (c == 30) exp_bc = 0;
            @(negedge clk);
            es = (c % 8 == 4) && ((c < 30) || (c >= 36));
            chk("s5_shift", c, 32'(shift_enable), 32'(es));
            chk("s5_br", c, 32'(byte_received), 32'd0);
            chk("s5_bc", c, 32'(bit_count), 32'(exp_bc));
            chk("s5_err", c, 32'(bit_error), 32'd0);
            if (es) exp_bc = (exp_bc == 7) ? 0 : exp_bc + 1;
            next_cycle();
        end
        n_rst = 1'b1;

        // Enable drops at cycle 40 with four bits taken.
        idle();
        exp_bc = 0;
        for (int c = 0; c <= 50; c++) begin
            enable_timer = (c < 40);
            d_edge       = (c % 8 == 0) && (c < 40);
            stuff_bit    = (c == 36);
            @(negedge clk);
            es = (c % 8 == 4) && (c < 40) && (c != 36);
            chk("s6_shift", c, 32'(shift_enable), 32'(es));
            chk("s6_br", c, 32'(byte_received), 32'd0);
            chk("s6_bc", c, 32'(bit_count), 32'(exp_bc));
            if (c == 40) chk("s6_bc40", c, 32'(bit_count), 32'd4);
            if (es) exp_bc = exp_bc + 1;
            if (c >= 40) exp_bc = 0;
            next_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
